// File: rtl/cv32e40p_rf_recovery_seq_if.sv
// Bundle of the recovery request, backup-source read port and core recovery outputs
// shared between the recovery sequencer (master) and its environment (slave).
interface cv32e40p_rf_recovery_seq_if;
    logic        start_i;
    logic        abort_i;
    logic [31:0] bkp_pc_i;
    logic        bkp_branch_i;
    logic [31:0] bkp_branch_addr_i;
    logic        bkp_read_o;
    logic [5:0]  bkp_raddr_a_o;
    logic [5:0]  bkp_raddr_b_o;
    logic [31:0] bkp_rdata_a_i;
    logic [31:0] bkp_rdata_b_i;
    logic        recover_o;
    logic        regfile_we_a_o;
    logic [5:0]  regfile_waddr_a_o;
    logic [31:0] regfile_wdata_a_o;
    logic        regfile_we_b_o;
    logic [5:0]  regfile_waddr_b_o;
    logic [31:0] regfile_wdata_b_o;
    logic        pc_recover_o;
    logic [31:0] recovery_program_counter_o;
    logic        recovery_branch_o;
    logic [31:0] recovery_branch_addr_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        input  start_i, abort_i, bkp_pc_i, bkp_branch_i, bkp_branch_addr_i,
               bkp_rdata_a_i, bkp_rdata_b_i,
        output bkp_read_o, bkp_raddr_a_o, bkp_raddr_b_o, recover_o,
               regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
               regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
               pc_recover_o, recovery_program_counter_o, recovery_branch_o,
               recovery_branch_addr_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, bkp_pc_i, bkp_branch_i, bkp_branch_addr_i,
               bkp_rdata_a_i, bkp_rdata_b_i,
        input  bkp_read_o, bkp_raddr_a_o, bkp_raddr_b_o, recover_o,
               regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
               regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
               pc_recover_o, recovery_program_counter_o, recovery_branch_o,
               recovery_branch_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/cv32e40p_rf_recovery_seq.sv
// Register-file recovery sequencer: replays a backed-up RF image two registers per
// cycle into the core while holding it in recover mode, then fires one PC recovery.
module cv32e40p_rf_recovery_seq #(
    parameter int unsigned NUM_REGS = 32,
    parameter bit          SKIP_X0  = 1'b1
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    cv32e40p_rf_recovery_seq_if.master   rec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        PC    = 2'd3
    } state_e;

    localparam logic [5:0] LAST_PAIR = 6'(NUM_REGS / 2 - 1);

    state_e      state_r;
    state_e      state_next_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_next_s;
    logic        wr_valid_r;
    logic        wr_valid_next_s;
    logic [5:0]  wr_addr_r;
    logic [5:0]  wr_addr_next_s;
    logic        capture_s;
    logic [31:0] pc_r;
    logic        branch_r;
    logic [31:0] branch_addr_r;
    logic        in_read_s;
    logic [5:0]  pair_addr_s;

    assign pair_addr_s = cnt_r + cnt_r;

    // Next-state, pair counter and write-pipeline staging
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        wr_valid_next_s = 1'b0;
        wr_addr_next_s  = wr_addr_r;
        capture_s       = 1'b0;
        if (rec.abort_i) begin
            // Abort also acts as the synchronous soft reset of the sequence.
            state_next_s = IDLE;
            cnt_next_s   = 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rec.start_i) begin
                        capture_s    = 1'b1;
                        state_next_s = READ;
                        cnt_next_s   = 6'd0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                READ: begin
                    wr_valid_next_s = 1'b1;
                    wr_addr_next_s  = pair_addr_s;
                    if (cnt_r == LAST_PAIR) begin
                        state_next_s = DRAIN;
                        cnt_next_s   = 6'd0;
                    end else begin
                        cnt_next_s   = cnt_r + 6'd1;
                    end
                end
                DRAIN:   state_next_s = PC;
                PC:      state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Sequencer state, pair counter and registered write address/enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            cnt_r      <= 6'd0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 6'd0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            wr_valid_r <= wr_valid_next_s;
            wr_addr_r  <= wr_addr_next_s;
        end
    end

    // Captured PC/branch state, retained across aborts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r          <= 32'h0000_0000;
            branch_r      <= 1'b0;
            branch_addr_r <= 32'h0000_0000;
        end else if (capture_s) begin
            pc_r          <= rec.bkp_pc_i;
            branch_r      <= rec.bkp_branch_i;
            branch_addr_r <= rec.bkp_branch_addr_i;
        end
    end

    assign in_read_s         = (state_r == READ);
    assign rec.bkp_read_o    = in_read_s;
    assign rec.bkp_raddr_a_o = in_read_s ? pair_addr_s : 6'd0;
    assign rec.bkp_raddr_b_o = in_read_s ? (pair_addr_s | 6'd1) : 6'd0;

    assign rec.busy_o        = (state_r != IDLE);
    assign rec.recover_o     = (state_r != IDLE);
    assign rec.pc_recover_o  = (state_r == PC);
    assign rec.done_o        = (state_r == PC);

    // Write data comes straight from the backup source; address/enable are the staged copies.
    assign rec.regfile_we_a_o    = wr_valid_r & ~(SKIP_X0 && (wr_addr_r == 6'd0));
    assign rec.regfile_waddr_a_o = wr_valid_r ? wr_addr_r : 6'd0;
    assign rec.regfile_wdata_a_o = wr_valid_r ? rec.bkp_rdata_a_i : 32'h0000_0000;
    assign rec.regfile_we_b_o    = wr_valid_r;
    assign rec.regfile_waddr_b_o = wr_valid_r ? (wr_addr_r | 6'd1) : 6'd0;
    assign rec.regfile_wdata_b_o = wr_valid_r ? rec.bkp_rdata_b_i : 32'h0000_0000;

    assign rec.recovery_program_counter_o = pc_r;
    assign rec.recovery_branch_o          = branch_r;
    assign rec.recovery_branch_addr_o     = branch_addr_r;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_seq.sv
// Directed bench: a per-cycle vector table for the nominal 32-register sequence plus
// hand-written sequences for restart, abort, reset and the 64-register variant.
module tb_cv32e40p_rf_recovery_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40p_rf_recovery_seq_if if0 ();
    cv32e40p_rf_recovery_seq_if if1 ();

    cv32e40p_rf_recovery_seq #(.NUM_REGS(32), .SKIP_X0(1'b1)) dut0 (
        .clk_i (clk), .rst_ni(rst_n), .rec(if0.master));
    cv32e40p_rf_recovery_seq #(.NUM_REGS(64), .SKIP_X0(1'b0)) dut1 (
        .clk_i (clk), .rst_ni(rst_n), .rec(if1.master));

    // Backup source: data = 0x1000 + address, valid the cycle after the strobe
    always @(posedge clk) begin
        if (if0.bkp_read_o) begin
            if0.bkp_rdata_a_i <= 32'h1000 + 32'(if0.bkp_raddr_a_o);
            if0.bkp_rdata_b_i <= 32'h1000 + 32'(if0.bkp_raddr_b_o);
        end
        if (if1.bkp_read_o) begin
            if1.bkp_rdata_a_i <= 32'h1000 + 32'(if1.bkp_raddr_a_o);
            if1.bkp_rdata_b_i <= 32'h1000 + 32'(if1.bkp_raddr_b_o);
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        start;
        logic        busy;
        logic        rd;
        logic [5:0]  raddr_a;
        logic [5:0]  raddr_b;
        logic        wr;
        logic        we_a;
        logic        we_b;
        logic [5:0]  waddr_a;
        logic [31:0] wdata_a;
        logic [5:0]  waddr_b;
        logic [31:0] wdata_b;
        logic        pcr;
        logic [31:0] rpc;
        logic        rbr;
        logic [31:0] rbaddr;
    } vec_t;

    vec_t tbl [0:20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int found;
        int cnt_a;
        int cnt_b;

        // Nominal sequence table: start at 0, ignored pulses at 5 and 18, restart at 19
        for (int n = 0; n <= 20; n++) begin
            tbl[n] = '0;
            tbl[n].start = (n == 0 || n == 5 || n == 18 || n == 19);
            tbl[n].busy  = ((n >= 1 && n <= 18) || n == 20);
            if (n >= 1 && n <= 16) begin
                tbl[n].rd      = 1'b1;
                tbl[n].raddr_a = 6'(2 * (n - 1));
                tbl[n].raddr_b = 6'(2 * (n - 1) + 1);
            end else if (n == 20) begin
                tbl[n].rd      = 1'b1;
                tbl[n].raddr_a = 6'd0;
                tbl[n].raddr_b = 6'd1;
            end
            if (n >= 2 && n <= 17) begin
                tbl[n].wr      = 1'b1;
                tbl[n].we_a    = (n != 2);
                tbl[n].we_b    = 1'b1;
                tbl[n].waddr_a = 6'(2 * (n - 2));
                tbl[n].wdata_a = 32'h1000 + 32'(2 * (n - 2));
                tbl[n].waddr_b = 6'(2 * (n - 2) + 1);
                tbl[n].wdata_b = 32'h1000 + 32'(2 * (n - 2) + 1);
            end
            tbl[n].pcr = (n == 18);
            if (n >= 1 && n <= 19) begin
                tbl[n].rpc    = 32'h0000_1A40;
                tbl[n].rbr    = 1'b1;
                tbl[n].rbaddr = 32'h0000_2000;
            end
        end

        if0.start_i = 1'b0; if0.abort_i = 1'b0;
        if0.bkp_pc_i = 32'h0; if0.bkp_branch_i = 1'b0; if0.bkp_branch_addr_i = 32'h0;
        if1.start_i = 1'b0; if1.abort_i = 1'b0;
        if1.bkp_pc_i = 32'h0; if1.bkp_branch_i = 1'b0; if1.bkp_branch_addr_i = 32'h0;

        step();
        chk("reset_busy", 0, 32'(if0.busy_o), 32'd0);
        chk("reset_recover", 0, 32'(if0.recover_o), 32'd0);
        chk("reset_we_b", 0, 32'(if0.regfile_we_b_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table-driven nominal run
        for (int n = 0; n <= 20; n++) begin
            chk("busy", n, 32'(if0.busy_o), 32'(tbl[n].busy));
            chk("recover", n, 32'(if0.recover_o), 32'(tbl[n].busy));
            chk("bkp_read", n, 32'(if0.bkp_read_o), 32'(tbl[n].rd));
            if (tbl[n].rd) begin
                chk("raddr_a", n, 32'(if0.bkp_raddr_a_o), 32'(tbl[n].raddr_a));
                chk("raddr_b", n, 32'(if0.bkp_raddr_b_o), 32'(tbl[n].raddr_b));
            end
            chk("we_a", n, 32'(if0.regfile_we_a_o), 32'(tbl[n].we_a));
            chk("we_b", n, 32'(if0.regfile_we_b_o), 32'(tbl[n].we_b));
            if (tbl[n].wr) begin
                chk("waddr_a", n, 32'(if0.regfile_waddr_a_o), 32'(tbl[n].waddr_a));
                chk("wdata_a", n, if0.regfile_wdata_a_o, tbl[n].wdata_a);
                chk("waddr_b", n, 32'(if0.regfile_waddr_b_o), 32'(tbl[n].waddr_b));
                chk("wdata_b", n, if0.regfile_wdata_b_o, tbl[n].wdata_b);
            end
            chk("pc_recover", n, 32'(if0.pc_recover_o), 32'(tbl[n].pcr));
            chk("done", n, 32'(if0.done_o), 32'(tbl[n].pcr));
            chk("rec_pc", n, if0.recovery_program_counter_o, tbl[n].rpc);
            chk("rec_branch", n, 32'(if0.recovery_branch_o), 32'(tbl[n].rbr));
            chk("rec_branch_addr", n, if0.recovery_branch_addr_o, tbl[n].rbaddr);
            if0.start_i           = tbl[n].start;
            if0.bkp_pc_i          = (n == 0) ? 32'h0000_1A40 : 32'h0;
            if0.bkp_branch_i      = (n == 0);
            if0.bkp_branch_addr_i = (n == 0) ? 32'h0000_2000 : 32'h0;
            step();
        end
        if0.start_i = 1'b0;

        // Second sequence (started at cycle 19) must complete at cycle 37
        found = 0;
        for (int i = 21; i < 60 && found == 0; i++) begin
            if (if0.done_o) begin
                found = 1;
                chk("seq2_done_cycle", i, 32'(i), 32'd37);
                chk("seq2_rec_pc", i, if0.recovery_program_counter_o, 32'h0);
            end else begin
                step();
            end
        end
        if (found == 0) chk("seq2_done_timeout", 60, 32'd0, 32'd1);
        step();
        chk("seq2_idle", 0, 32'(if0.busy_o), 32'd0);

        // Abort at cycle 8
        if0.start_i = 1'b1; if0.bkp_pc_i = 32'h5555_0000;
        step();
        if0.start_i = 1'b0; if0.bkp_pc_i = 32'h0;
        for (int i = 1; i < 8; i++) step();
        chk("abort_pre_busy", 8, 32'(if0.busy_o), 32'd1);
        if0.abort_i = 1'b1;
        step();
        if0.abort_i = 1'b0;
        chk("abort_busy", 9, 32'(if0.busy_o), 32'd0);
        chk("abort_recover", 9, 32'(if0.recover_o), 32'd0);
        chk("abort_read", 9, 32'(if0.bkp_read_o), 32'd0);
        chk("abort_we_a", 9, 32'(if0.regfile_we_a_o), 32'd0);
        chk("abort_we_b", 9, 32'(if0.regfile_we_b_o), 32'd0);
        chk("abort_done", 9, 32'(if0.done_o), 32'd0);
        chk("abort_pc_kept", 9, if0.recovery_program_counter_o, 32'h5555_0000);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            if (if0.done_o) cnt_a++;
            if (if0.regfile_we_a_o || if0.regfile_we_b_o || if0.busy_o) cnt_b++;
            step();
        end
        chk("abort_no_done", 0, 32'(cnt_a), 32'd0);
        chk("abort_no_activity", 0, 32'(cnt_b), 32'd0);

        // Abort and start together in IDLE: abort wins
        if0.start_i = 1'b1; if0.abort_i = 1'b1; if0.bkp_pc_i = 32'h0BAD_0000;
        step();
        if0.start_i = 1'b0; if0.abort_i = 1'b0;
        chk("abort_start_idle", 1, 32'(if0.busy_o), 32'd0);
        chk("abort_start_no_capture", 1, if0.recovery_program_counter_o, 32'h5555_0000);

        // Restart after abort completes normally at cycle 18
        if0.start_i = 1'b1; if0.bkp_pc_i = 32'hCAFE_0000;
        step();
        if0.start_i = 1'b0; if0.bkp_pc_i = 32'h0;
        found = 0;
        for (int i = 1; i < 40 && found == 0; i++) begin
            if (if0.done_o) begin
                found = 1;
                chk("post_abort_done_cycle", i, 32'(i), 32'd18);
                chk("post_abort_rec_pc", i, if0.recovery_program_counter_o, 32'hCAFE_0000);
            end else begin
                step();
            end
        end
        if (found == 0) chk("post_abort_done_timeout", 40, 32'd0, 32'd1);
        step(); step();

        // Asynchronous reset at cycle 10
        if0.start_i = 1'b1; if0.bkp_pc_i = 32'h1234_0000;
        step();
        if0.start_i = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("rst_pre_busy", 10, 32'(if0.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 10, 32'(if0.busy_o), 32'd0);
        chk("rst_recover", 10, 32'(if0.recover_o), 32'd0);
        chk("rst_read", 10, 32'(if0.bkp_read_o), 32'd0);
        chk("rst_raddr_a", 10, 32'(if0.bkp_raddr_a_o), 32'd0);
        chk("rst_we_a", 10, 32'(if0.regfile_we_a_o), 32'd0);
        chk("rst_we_b", 10, 32'(if0.regfile_we_b_o), 32'd0);
        chk("rst_waddr_b", 10, 32'(if0.regfile_waddr_b_o), 32'd0);
        chk("rst_wdata_b", 10, if0.regfile_wdata_b_o, 32'd0);
        chk("rst_pc_recover", 10, 32'(if0.pc_recover_o), 32'd0);
        chk("rst_rec_pc", 10, if0.recovery_program_counter_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        if0.start_i = 1'b1; if0.bkp_pc_i = 32'h0000_0BEE;
        step();
        if0.start_i = 1'b0; if0.bkp_pc_i = 32'h0;
        chk("post_rst_read", 1, 32'(if0.bkp_read_o), 32'd1);
        chk("post_rst_raddr_b", 1, 32'(if0.bkp_raddr_b_o), 32'd1);
        step();
        chk("post_rst_we_a", 2, 32'(if0.regfile_we_a_o), 32'd0);
        chk("post_rst_we_b", 2, 32'(if0.regfile_we_b_o), 32'd1);
        chk("post_rst_wdata_b", 2, if0.regfile_wdata_b_o, 32'h0000_1001);
        found = 0;
        for (int i = 2; i < 40 && found == 0; i++) begin
            if (if0.done_o) begin
                found = 1;
                chk("post_rst_done_cycle", i, 32'(i), 32'd18);
                chk("post_rst_rec_pc", i, if0.recovery_program_counter_o, 32'h0000_0BEE);
            end else begin
                step();
            end
        end
        if (found == 0) chk("post_rst_done_timeout", 40, 32'd0, 32'd1);
        step(); step();

        // 64 registers, x0 written
        if1.start_i = 1'b1;
        step();
        if1.start_i = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 36; c++) begin
            if (if1.bkp_read_o) cnt_a++;
            if (if1.busy_o) cnt_b++;
            if (c == 2) begin
                chk("r64_we_a_x0", c, 32'(if1.regfile_we_a_o), 32'd1);
                chk("r64_waddr_a_x0", c, 32'(if1.regfile_waddr_a_o), 32'd0);
                chk("r64_wdata_a_x0", c, if1.regfile_wdata_a_o, 32'h0000_1000);
            end
            if (c == 32) chk("r64_last_raddr_a", c, 32'(if1.bkp_raddr_a_o), 32'd62);
            if (c == 33) begin
                chk("r64_drain_read", c, 32'(if1.bkp_read_o), 32'd0);
                chk("r64_last_waddr_a", c, 32'(if1.regfile_waddr_a_o), 32'd62);
                chk("r64_last_waddr_b", c, 32'(if1.regfile_waddr_b_o), 32'd63);
                chk("r64_last_wdata_b", c, if1.regfile_wdata_b_o, 32'h0000_103F);
            end
            if (c == 34) chk("r64_done", c, 32'(if1.done_o), 32'd1);
            if (c == 35) chk("r64_idle", c, 32'(if1.busy_o), 32'd0);
            step();
        end
        chk("r64_read_cycles", 0, 32'(cnt_a), 32'd32);
        chk("r64_busy_cycles", 0, 32'(cnt_b), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cv32e40p_rf_recovery_seq.md
Name: cv32e40p_rf_recovery_seq

Overview:
- Recovery sequencer that sits directly upstream of the core wrapper's recovery inputs.
- On a recovery request it reads a saved register-file image and a saved PC/branch state from a backup source, two registers per cycle.
- It replays them into the core through write ports A/B while holding the core in recover mode, then fires a single-cycle PC recovery.
- Used for lockstep/setback recovery flows.

Parameters:
- NUM_REGS, 32, registers restored (must be even, 2..64; use 64 when FPU=1 and PULP_ZFINX=0).
- SKIP_X0, 1, when 1 the write enable is suppressed for address 0.

Ports:
- clk_i in 1: core clock.
- rst_ni in 1: asynchronous active-low reset.
- start_i in 1: recovery request; sampled in IDLE only.
- abort_i in 1: synchronous abort; returns the block to IDLE.
- bkp_pc_i in 32: saved program counter.
- bkp_branch_i in 1: saved branch flag.
- bkp_branch_addr_i in 32: saved branch target.
- bkp_read_o out 1: backup RF read strobe.
- bkp_raddr_a_o out 6: backup read address, port A.
- bkp_raddr_b_o out 6: backup read address, port B.
- bkp_rdata_a_i in 32: backup read data A; valid the cycle after the read strobe.
- bkp_rdata_b_i in 32: backup read data B; same timing as A.
- recover_o out 1: drives the core's recover_i.
- regfile_we_a_o out 1: core RF write enable, port A.
- regfile_waddr_a_o out 6: core RF write address, port A.
- regfile_wdata_a_o out 32: core RF write data, port A.
- regfile_we_b_o out 1: core RF write enable, port B.
- regfile_waddr_b_o out 6: core RF write address, port B.
- regfile_wdata_b_o out 32: core RF write data, port B.
- pc_recover_o out 1: drives the core's pc_recover_i.
- recovery_program_counter_o out 32: PC value presented with pc_recover_o.
- recovery_branch_o out 1: branch flag presented with pc_recover_o.
- recovery_branch_addr_o out 32: branch target presented with pc_recover_o.
- busy_o out 1: sequence in progress.
- done_o out 1: one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, pair counter 0, captured PC/branch registers 0.
- States: IDLE, READ, DRAIN, PC.
- IDLE:
  - start_i=1 → capture bkp_pc_i, bkp_branch_i, bkp_branch_addr_i; next state READ; pair counter k=0.
- READ (NUM_REGS/2 cycles):
  - bkp_read_o=1; bkp_raddr_a_o=2k; bkp_raddr_b_o=2k+1.
  - k increments each cycle.
  - After pair NUM_REGS/2-1 → DRAIN.
- Write pipeline, active in READ and DRAIN:
  - Addresses are registered one cycle behind the reads.
  - In the cycle after pair k is read: regfile_waddr_a_o=2k, regfile_wdata_a_o=bkp_rdata_a_i, regfile_we_a_o=1; port B likewise with 2k+1.
  - Write data is bkp_rdata_*_i taken combinationally; address and enable are registered.
  - SKIP_X0=1: regfile_we_a_o=0 whenever the write address is 0.
  - No write in the first READ cycle.
- DRAIN (1 cycle): last pair written; bkp_read_o=0; next state PC.
- PC (1 cycle):
  - pc_recover_o=1; recovery_* outputs show the captured values.
  - done_o=1; no RF writes.
  - Next state IDLE.
- recover_o=1 and busy_o=1 in READ, DRAIN and PC; 0 in IDLE.
- Outside PC, recovery_* outputs hold the captured values; they are only qualified by pc_recover_o.
- Latency (NUM_REGS=32), start_i high at cycle 0:
  - READ cycles 1..16; writes cycles 2..17; DRAIN cycle 17; PC/done cycle 18; IDLE cycle 19.
  - General total: NUM_REGS/2+2 busy cycles.
- start_i while busy: ignored; not queued.
- start_i in the same cycle done_o=1: ignored; a new start is accepted from IDLE on the next cycle.
- abort_i: highest priority after reset.
  - Any state → IDLE on the next edge; all strobes 0 that cycle; no done_o.
  - Any in-flight write that has not yet issued is dropped.
  - Captured values are retained.
- abort_i and start_i together in IDLE: abort wins; stays IDLE.
- Asynchronous reset mid-sequence: immediate return to reset values; partial RF content in the core is left as is.
- Counter is 6 bits; addresses never exceed NUM_REGS-1; no wrap-around.

Test Plan:
- NUM_REGS=32, backup rdata = 0x1000+addr, start at cycle 0 → writes A/B addr (2k,2k+1) with data 0x1000+2k/0x1000+2k+1 on cycles k+2; we_a=0 for addr 0; pc_recover_o=done_o=1 at cycle 18 only; busy_o high cycles 1..18.
- bkp_pc_i=0x0000_1A40, bkp_branch_i=1, bkp_branch_addr_i=0x0000_2000 at start, changed to 0 afterwards → PC cycle shows 0x1A40/1/0x2000.
- start_i pulsed again at cycles 5 and 18 → ignored, exactly one done_o; start at cycle 19 → a second sequence begins at cycle 20.
- abort_i at cycle 8 → cycle 9: IDLE, recover_o=0, no further writes, done_o never asserted; a later start completes normally.
- rst_ni low at cycle 10 → all outputs 0 immediately; after release, start at a new cycle 0 gives nominal timing.
- NUM_REGS=64, SKIP_X0=0 → 32 READ cycles; addr 0 written with we_a=1; last write addr 62/63 at cycle 33; PC cycle 34.
